rr_share_ctrl: RTL and testbench
================================

Name: rr_share_ctrl

Overview:
- Round-robin scheduler sharing one single-transaction resource among N requesters.
- The resource is a fizzim2-style run/last FSM: one owner at a time, with a bounded burst per grant and a one-cycle release turnaround.
- Outputs deliberately mix three styles: registered on-state (busy, rel), combinational on-transit (start, timeout) and registered on-both (gnt, gnt_id).
- Serves as a bench example and as the reusable sharing controller in front of the datapath FSMs.

Parameters:
- N, 4, number of requesters; must be at least 2.
- MAX_BURST, 8, maximum BUSY cycles per grant; must be at least 2.
- IDW, $clog2(N), width of gnt_id; derived, not overridden.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  N  request vector; bit i set means requester i wants the resource.
- done  input  1  resource signals the current transaction is complete.
- gnt  output  N  registered one-hot grant; all zero when not BUSY.
- gnt_id  output  IDW  registered index of the current or last owner.
- busy  output  1  registered; high while state is BUSY.
- rel  output  1  registered; high while state is LAST (release cycle).
- start  output  1  combinational pulse on the IDLE->BUSY transition.
- timeout  output  1  combinational pulse when a burst is cut at MAX_BURST.

Behaviour:
- Reset values: state IDLE; gnt=0, gnt_id=0, busy=0, rel=0; cnt=0; ptr=N-1, so requester 0 has first priority.
- Reset asserted mid-grant: all outputs drop asynchronously; no rel pulse is generated.
- States are IDLE, BUSY and LAST; 2-bit encoding; undefined encodings go to IDLE.
- IDLE, no req: stay in IDLE; all combinational outputs 0.
- IDLE, req != 0: winner is the first set bit searching ptr+1, ptr+2, ... modulo N.
  - start=1 in the same cycle.
  - nextstate=BUSY.
  - gnt[winner], gnt_id=winner and busy are set on the next edge, so grant latency is 1 cycle after req is seen in IDLE.
- BUSY: cnt increments each cycle, starting at 0 on the first BUSY cycle. Exit to LAST when any of these holds:
  - done=1;
  - req[gnt_id]=0 (owner withdrew);
  - cnt==MAX_BURST-1.
- timeout=1 only if the exit cause is cnt==MAX_BURST-1 AND done=0 AND req[gnt_id]=1. If done coincides with the limit, done wins and timeout=0.
- Leaving BUSY: gnt clears and busy clears on the edge into LAST; ptr<=gnt_id; gnt_id is held.
- LAST: rel=1 for exactly one cycle; unconditional transition to IDLE; req is ignored.
- Turnaround: minimum 2 grant-free cycles (LAST, then IDLE) between successive grants.
- Maximum grant tenure is MAX_BURST cycles; minimum is 1 (done in the first BUSY cycle).
- Changes to non-owner req bits during BUSY or LAST have no effect.
- Invariants:
  - gnt is always one-hot or zero.
  - gnt != 0 exactly when busy=1.
  - start and timeout are never high in the same cycle.
  - Fairness: with all req held high, grants rotate 0,1,2,3,0,...
- Scheduling of cnt: cnt clears on entering BUSY and saturates-free (width $clog2(MAX_BURST)).
- Implementation structure: one combinational transition block, plus one output sequential block keyed on nextstate. `ifndef SYNTHESIS state_name decoder included.

Test Plan:
- Single requester: reset, req=4'b0100 held, done pulsed on the 3rd BUSY cycle.
  - start high at cycle t; gnt=4'b0100 and gnt_id=2 from t+1 to t+3.
  - rel at t+4; IDLE at t+5; regrant start at t+5.
- All four requesters held high with done on each first BUSY cycle.
  - Grant order is 0,1,2,3,0.
  - Each grant lasts 1 cycle, separated by exactly 2 grant-free cycles.
- Burst limit: req=4'b0001 held, done=0.
  - gnt holds for exactly 8 cycles.
  - timeout=1 on the 8th BUSY cycle; rel follows.
- done and limit coincide: done=1 when cnt=7 -> timeout=0; normal LAST.
- Owner withdraws: req[1] dropped in the 2nd BUSY cycle while req[3]=1.
  - LAST follows immediately, no timeout.
  - Next grant goes to 3.
- Reset mid-BUSY: rst_n low for 1 cycle -> gnt, busy and rel go 0 immediately, no rel pulse; the first grant after reset goes to the lowest set req bit.

Source files
------------

// File: rtl/rr_share_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rr_share_ctrl : round-robin owner scheduler for one shared resource      |
// | Revision      : 1.0                                                      |
// +--------------------------------------------------------------------------+
module rr_share_ctrl #(
   parameter int N         = 4,
   parameter int MAX_BURST = 8,
   parameter int IDW       = $clog2(N)
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [N-1:0]   req,
   input  logic           done,
   output logic [N-1:0]   gnt,
   output logic [IDW-1:0] gnt_id,
   output logic           busy,
   output logic           rel,
   output logic           start,
   output logic           timeout
);

   localparam int CW = $clog2(MAX_BURST);
   localparam logic [CW-1:0]  C_CNT_LAST = CW'(MAX_BURST - 1);
   localparam logic [IDW-1:0] C_PTR_INIT = IDW'(N - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      LAST = 2'd2
   } state_t;

   state_t         r_state;
   state_t         w_next;
   logic [CW-1:0]  r_cnt;
   logic [IDW-1:0] r_ptr;
   logic [IDW-1:0] w_winner;
   logic [IDW-1:0] w_idx;
   logic           w_found;
   logic           w_at_limit;
   logic           w_owner_req;

   // Search starts one past the last owner, so the last owner has lowest priority.
   always_comb begin
      w_winner = '0;
      w_found  = 1'b0;
      w_idx    = '0;
      for (int k = 1; k <= N; k++) begin
         w_idx = IDW'((int'(r_ptr) + k) % N);
         if (!w_found && req[w_idx]) begin
            w_found  = 1'b1;
            w_winner = w_idx;
         end
      end
   end

   assign w_at_limit  = (r_cnt == C_CNT_LAST);
   assign w_owner_req = req[gnt_id];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next  = IDLE;
      start   = 1'b0;
      timeout = 1'b0;
      case (r_state)
         IDLE: begin
            if (|req) begin
               w_next = BUSY;
               start  = rst_n;
            end
         end
         BUSY: begin
            w_next = BUSY;
            if (done || !w_owner_req || w_at_limit) w_next = LAST;
            // done takes precedence over the burst limit as the exit cause
            timeout = w_at_limit && !done && w_owner_req;
         end
         LAST:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gnt    <= '0;
         gnt_id <= '0;
         busy   <= 1'b0;
         rel    <= 1'b0;
         r_cnt  <= '0;
         r_ptr  <= C_PTR_INIT;
      end else begin
         case (w_next)
            BUSY: begin
               busy <= 1'b1;
               rel  <= 1'b0;
               if (r_state != BUSY) begin
                  gnt    <= N'(1) << w_winner;
                  gnt_id <= w_winner;
                  r_cnt  <= '0;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            LAST: begin
               gnt   <= '0;
               busy  <= 1'b0;
               rel   <= 1'b1;
               r_ptr <= gnt_id;
            end
            default: begin
               gnt  <= '0;
               busy <= 1'b0;
               rel  <= 1'b0;
            end
         endcase
      end
   end

`ifndef SYNTHESIS
   function automatic string state_name(input state_t s);
      case (s)
         IDLE:    return "IDLE";
         BUSY:    return "BUSY";
         LAST:    return "LAST";
         default: return "ILLEGAL";
      endcase
   endfunction
`endif

endmodule
`default_nettype wire

// File: tb/tb_rr_share_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_rr_share_ctrl : directed scoreboard bench for rr_share_ctrl           |
// | Revision         : 1.0                                                   |
// +--------------------------------------------------------------------------+
module tb_rr_share_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] req;
   logic       done;
   logic [3:0] gnt;
   logic [1:0] gnt_id;
   logic       busy;
   logic       rel;
   logic       start;
   logic       timeout;

   typedef struct {
      string      tag;
      logic [9:0] v;
   } exp_t;

   exp_t q[$];
   int   n_vec  = 0;
   int   n_fail = 0;

   rr_share_ctrl #(.N(4), .MAX_BURST(8)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req),
      .done    (done),
      .gnt     (gnt),
      .gnt_id  (gnt_id),
      .busy    (busy),
      .rel     (rel),
      .start   (start),
      .timeout (timeout)
   );

   always #5 clk = ~clk;

   // vector layout: {gnt, gnt_id, busy, rel, start, timeout}
   task automatic push(input string tag, input logic [3:0] eg, input logic [1:0] eid,
                       input logic eb, input logic er, input logic es, input logic et);
      exp_t e;
      e.tag = tag;
      e.v   = {eg, eid, eb, er, es, et};
      q.push_back(e);
   endtask

   task automatic check();
      exp_t       e;
      logic [9:0] obs;
      obs = {gnt, gnt_id, busy, rel, start, timeout};
      n_vec++;
      if (q.size() == 0) begin
         n_fail++;
         $error("FAIL scoreboard_empty: observed %b required an expectation", obs);
      end else begin
         e = q.pop_front();
         assert (obs === e.v) else begin
            n_fail++;
            $error("FAIL %s: observed %b required %b", e.tag, obs, e.v);
         end
      end
   endtask

   task automatic cyc(input string tag, input logic [3:0] r, input logic d,
                      input logic [3:0] eg, input logic [1:0] eid,
                      input logic eb, input logic er, input logic es, input logic et);
      req  = r;
      done = d;
      push(tag, eg, eid, eb, er, es, et);
      @(negedge clk);
      check();
      @(posedge clk);
      #1;
   endtask

   // Called 1 time unit after a rising edge; holds reset for one cycle.
   task automatic pulse_reset(input string tag);
      rst_n = 1'b0;
      #1;
      push({tag, "_async"}, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      check();
      @(negedge clk);
      push({tag, "_held"}, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      check();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, required finish before time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0;
      req   = 4'b0000;
      done  = 1'b0;
      @(negedge clk);
      push("reset", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      check();
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // single requester, done on third BUSY cycle, then immediate regrant
      cyc("s_start",  4'b0100, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      cyc("s_busy1",  4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc("s_busy2",  4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc("s_busy3",  4'b0100, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc("s_last",   4'b0100, 1'b0, 4'b0000, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0);
      cyc("s_regnt",  4'b0100, 1'b0, 4'b0000, 2'd2, 1'b0, 1'b0, 1'b1, 1'b0);
      cyc("s_busy1b", 4'b0100, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc("s_lastb",  4'b0000, 1'b0, 4'b0000, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0);
      cyc("s_idle",   4'b0000, 1'b0, 4'b0000, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0);

      pulse_reset("rst_idle");

      // all requesters held, one-cycle grants rotating 0,1,2,3,0
      for (int i = 0; i < 5; i++) begin
         logic [1:0] prev;
         logic [1:0] id;
         prev = (i == 0) ? 2'd0 : 2'(i - 1);
         id   = 2'(i);
         cyc($sformatf("rr%0d_start", i), 4'b1111, 1'b1, 4'b0000, prev, 1'b0, 1'b0, 1'b1, 1'b0);
         cyc($sformatf("rr%0d_gnt", i),   4'b1111, 1'b1, 4'b0001 << id, id, 1'b1, 1'b0, 1'b0, 1'b0);
         if (i < 4)
            cyc($sformatf("rr%0d_last", i), 4'b1111, 1'b1, 4'b0000, id, 1'b0, 1'b1, 1'b0, 1'b0);
      end
      cyc("rr_last_end", 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      cyc("rr_idle_end", 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);

      // burst limit: eight BUSY cycles, timeout on the eighth
      cyc("bl_start", 4'b0001, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      for (int c = 1; c <= 8; c++)
         cyc($sformatf("bl_busy%0d", c), 4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0, 1'b0, c == 8);
      cyc("bl_last", 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      cyc("bl_idle", 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);

      // done coincides with the limit: no timeout
      cyc("dl_start", 4'b0001, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      for (int c = 1; c <= 8; c++)
         cyc($sformatf("dl_busy%0d", c), 4'b0001, c == 8, 4'b0001, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc("dl_last", 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      cyc("dl_idle", 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);

      // owner 1 withdraws in its second BUSY cycle, requester 3 gets next grant
      cyc("wd_start", 4'b1010, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      cyc("wd_busy1", 4'b1011, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc("wd_busy2", 4'b1000, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc("wd_last",  4'b1000, 1'b0, 4'b0000, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0);
      cyc("wd_next",  4'b1000, 1'b0, 4'b0000, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0);
      cyc("wd_gnt3",  4'b1000, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc("wd_last3", 4'b0000, 1'b0, 4'b0000, 2'd3, 1'b0, 1'b1, 1'b0, 1'b0);
      cyc("wd_idle",  4'b0000, 1'b0, 4'b0000, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0);

      // reset mid-BUSY; afterwards lowest set request bit wins
      cyc("mr_start", 4'b0100, 1'b0, 4'b0000, 2'd3, 1'b0, 1'b0, 1'b1, 1'b0);
      cyc("mr_busy1", 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc("mr_busy2", 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0);
      pulse_reset("rst_busy");
      cyc("mr_after", 4'b1010, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      cyc("mr_gnt1",  4'b1010, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc("mr_last",  4'b0000, 1'b0, 4'b0000, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0);
      cyc("mr_idle",  4'b0000, 1'b0, 4'b0000, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
